audio_frame_clk_gen: RTL and testbench
======================================

Name: audio_frame_clk_gen

Overview:
Single-clock-domain timing generator for the audio path. It replaces divided-register clocks with clock-enable strobes.
- A fractional NCO sets the sample rate, so 44.1 kHz is exact on average from any system clock.
- On each sample tick the block frames one SPI transfer: ss_n low, then FRAME_BITS SCK periods with a programmable half-period.
- Consumers are the Pmod MIC SPI front end (sck, ss_n, edge strobes) and the DAC transmit path (sample_tick, frame_done).

Parameters:
- ACC_W, 32, NCO phase accumulator width.
- PHASE_INC, 1894081, accumulator increment per clk; round(44100 * 2^32 / 100 MHz).
- SCK_HALF_DIV, 20, clk cycles per SCK half-period; legal range >= 1. 20 gives 2.5 MHz at 100 MHz.
- FRAME_BITS, 16, SCK periods per frame; legal range >= 1.
- CPOL, 1, SCK idle level.
- BIT_W, 5, width of bit_idx; must hold FRAME_BITS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  NCO run; low freezes accumulator
- overrun_clr  in  1  clears overrun flag
- sample_tick  out  1  one-clk strobe at sample rate
- ss_n  out  1  frame select, active low
- sck  out  1  registered serial clock
- sck_lead  out  1  one-clk strobe, same cycle sck leaves idle level
- sck_trail  out  1  one-clk strobe, same cycle sck returns to idle level
- bit_idx  out  BIT_W  current bit, counts FRAME_BITS-1 down to 0
- frame_done  out  1  one-clk strobe when ss_n deasserts
- busy  out  1  high while state != IDLE
- overrun  out  1  sticky; tick arrived while busy

Behaviour:
- Reset values:
  - acc = 0, state = IDLE
  - ss_n = 1, sck = CPOL
  - sample_tick, sck_lead, sck_trail, frame_done, busy, overrun all = 0
  - bit_idx = FRAME_BITS-1, half-period counter = 0
  - Reset mid-frame aborts at the next edge; no frame_done is issued.
- NCO:
  - When enable=1: {carry, acc} <= acc + PHASE_INC (ACC_W+1 bits). sample_tick is the registered carry.
  - When enable=0: acc holds and no ticks are produced. A frame already in progress still completes.
- States: IDLE, SETUP, SHIFT, HOLD.
  - IDLE: on sample_tick=1, next cycle ss_n=0, busy=1, state=SETUP, bit_idx=FRAME_BITS-1, half counter=0.
  - SETUP: sck stays at CPOL for SCK_HALF_DIV cycles, then goes to SHIFT.
  - SHIFT: the half counter counts 0..SCK_HALF_DIV-1. At the wrap, sck toggles.
    - Leading toggle: pulse sck_lead.
    - Trailing toggle: pulse sck_trail. bit_idx decrements, except on the final trailing edge, where bit_idx stays 0.
    - After 2*FRAME_BITS toggles (last one is trailing, so sck=CPOL), go to HOLD.
  - HOLD: lasts SCK_HALF_DIV cycles. On exit, ss_n=1, frame_done=1 for one cycle, busy=0, state=IDLE, bit_idx=FRAME_BITS-1.
- Latency:
  - ss_n falls 1 clk after sample_tick.
  - First sck_lead occurs 2*SCK_HALF_DIV clk after ss_n falls.
  - ss_n is low for (2*FRAME_BITS+2)*SCK_HALF_DIV clk in total.
- Overrun: sample_tick while busy=1 sets overrun the next cycle. The tick is dropped and the frame is not restarted.
  - overrun_clr clears the flag.
  - Simultaneous set and clr: set wins.
- Back-to-back: a tick in the same cycle that frame_done pulses counts as busy, so it is an overrun. A tick one cycle later starts a new frame.
- Never glitch: sck and ss_n are driven only from flops; no combinational clock muxing.
- Constraint (verified by assertion in the bench): the frame length (2*FRAME_BITS+2)*SCK_HALF_DIV+1 must be less than floor(2^ACC_W/PHASE_INC). Otherwise overrun is expected.

Optional Feature:
- Macro AUDIO_CLK_RUNTIME_INC_EN.
- Defined:
  - Adds input phase_inc_in [ACC_W-1:0] and input phase_inc_ld.
  - On phase_inc_ld=1 the increment register loads phase_inc_in. The new value applies from the next clk.
  - Reset loads PHASE_INC. acc is not cleared on load.
- Not defined: ports are absent and the increment is the constant PHASE_INC.

Test Plan:
- Defaults, enable=1, run 10 ticks -> each tick-to-tick interval is 2267 or 2268 clk; the sum of 10 intervals is 22675 or 22676.
- Defaults, one frame -> ss_n low for exactly 680 clk; 16 sck_lead and 16 sck_trail pulses, spaced 20 clk apart; bit_idx reads 15..0 at the trailing strobes; first sck_lead 40 clk after ss_n falls; frame_done coincides with ss_n rising.
- CPOL=0 and CPOL=1 -> sck idles at CPOL whenever ss_n=1; first edge in the frame is away from CPOL.
- PHASE_INC=2^31, FRAME_BITS=2, SCK_HALF_DIV=1 -> ticks every 2 clk; overrun sets; overrun_clr pulsed together with a set-causing tick leaves overrun=1.
- enable dropped mid-frame -> the frame completes, frame_done pulses, no further ticks; acc value is unchanged across the disabled window.
- rst asserted mid-SHIFT -> next cycle ss_n=1, sck=CPOL, busy=0, acc=0, no frame_done; normal operation resumes after release.

Source files
------------

// File: rtl/audio_frame_clk_gen.sv
// audio_frame_clk_gen: fractional-NCO sample tick framing one SPI transfer (ss_n, sck, edge strobes).
// Define AUDIO_CLK_RUNTIME_INC_EN to add a runtime-loadable phase increment (phase_inc_in/phase_inc_ld).
module audio_frame_clk_gen #(
    parameter int unsigned      ACC_W        = 32,
    parameter logic [ACC_W-1:0] PHASE_INC    = ACC_W'(1894081),
    parameter int unsigned      SCK_HALF_DIV = 20,
    parameter int unsigned      FRAME_BITS   = 16,
    parameter logic             CPOL         = 1'b1,
    parameter int unsigned      BIT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             overrun_clr,
`ifdef AUDIO_CLK_RUNTIME_INC_EN
    input  logic [ACC_W-1:0] phase_inc_in,
    input  logic             phase_inc_ld,
`endif
    output logic             sample_tick,
    output logic             ss_n,
    output logic             sck,
    output logic             sck_lead,
    output logic             sck_trail,
    output logic [BIT_W-1:0] bit_idx,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun
);
    localparam int CNT_W = SCK_HALF_DIV > 1 ? $clog2(SCK_HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, inc;
    logic [ACC_W:0]   sum;
    logic             tick_q, tick_d, ss_n_q, ss_n_d, sck_q, sck_d;
    logic             lead_q, lead_d, trail_q, trail_d, done_q, done_d, ovr_q, ovr_d, wrap;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;

`ifdef AUDIO_CLK_RUNTIME_INC_EN
    logic [ACC_W-1:0] inc_q;
    always_ff @(posedge clk) inc_q <= rst ? PHASE_INC : (phase_inc_ld ? phase_inc_in : inc_q);
    assign inc = inc_q;
`else
    assign inc = PHASE_INC;
`endif

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, inc};
        acc_d   = enable ? sum[ACC_W-1:0] : acc_q;
        tick_d  = enable & sum[ACC_W];
        wrap    = cnt_q == CNT_LAST;
        state_d = state_q;
        ss_n_d  = ss_n_q;
        sck_d   = sck_q;
        lead_d  = 1'b0;
        trail_d = 1'b0;
        done_d  = 1'b0;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        // bit_idx steps after each trailing strobe, so the strobe cycle still shows the bit just clocked
        bit_d   = (trail_q && bit_q != '0) ? bit_q - 1'b1 : bit_q;
        ovr_d   = (tick_q && (state_q != IDLE || done_q)) | (ovr_q & ~overrun_clr);
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tick_q && !done_q) begin
                    state_d = SETUP;
                    ss_n_d  = 1'b0;
                    bit_d   = BIT_TOP;
                end
            end
            SETUP: if (wrap) state_d = SHIFT;
            SHIFT: if (wrap) begin
                sck_d   = ~sck_q;
                lead_d  = sck_q == CPOL;
                trail_d = sck_q != CPOL;
                if (sck_q != CPOL && bit_q == '0) state_d = HOLD;
            end
            HOLD: if (wrap) begin
                state_d = IDLE;
                ss_n_d  = 1'b1;
                done_d  = 1'b1;
                bit_d   = BIT_TOP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
            sck_q   <= CPOL;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= BIT_TOP;
        end else begin
            acc_q   <= acc_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            ss_n_q  <= ss_n_d;
            sck_q   <= sck_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign sample_tick = tick_q;
    assign ss_n        = ss_n_q;
    assign sck         = sck_q;
    assign sck_lead    = lead_q;
    assign sck_trail   = trail_q;
    assign bit_idx     = bit_q;
    assign frame_done  = done_q;
    assign busy        = state_q != IDLE;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_audio_frame_clk_gen.sv
// tb_audio_frame_clk_gen: default instance (A) checked by sequences and an NCO model,
// small CPOL=0 instance (C) checked cycle-by-cycle from a hand-computed vector table.
module tb_audio_frame_clk_gen;
    localparam logic [31:0] INC_A = 32'd1894081;
    localparam logic [31:0] INC_C = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a = 1'b1, en_a = 1'b0, clr_a = 1'b0;
    logic tick_a, ss_a, sck_a, lead_a, trail_a, done_a, busy_a, ov_a;
    logic [4:0] bit_a;
    logic rst_c = 1'b1, en_c = 1'b0, clr_c = 1'b0;
    logic tick_c, ss_c, sck_c, lead_c, trail_c, done_c, busy_c, ov_c;
    logic [4:0] bit_c;

    audio_frame_clk_gen dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .overrun_clr(clr_a),
`ifdef AUDIO_CLK_RUNTIME_INC_EN
        .phase_inc_in(INC_A), .phase_inc_ld(1'b0),
`endif
        .sample_tick(tick_a), .ss_n(ss_a), .sck(sck_a), .sck_lead(lead_a), .sck_trail(trail_a),
        .bit_idx(bit_a), .frame_done(done_a), .busy(busy_a), .overrun(ov_a)
    );

    audio_frame_clk_gen #(
        .ACC_W(32), .PHASE_INC(INC_C), .SCK_HALF_DIV(1), .FRAME_BITS(2), .CPOL(1'b0), .BIT_W(5)
    ) dut_c (
        .clk(clk), .rst(rst_c), .enable(en_c), .overrun_clr(clr_c),
`ifdef AUDIO_CLK_RUNTIME_INC_EN
        .phase_inc_in(INC_C), .phase_inc_ld(1'b0),
`endif
        .sample_tick(tick_c), .ss_n(ss_c), .sck(sck_c), .sck_lead(lead_c), .sck_trail(trail_c),
        .bit_idx(bit_c), .frame_done(done_c), .busy(busy_c), .overrun(ov_c)
    );

    initial assert ((2 * 16 + 2) * 20 + 1 < (64'd1 << 32) / 64'(INC_A))
        else $error("default frame does not fit in one sample period");

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_in(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference NCO for instance A: tick is the registered carry of acc + INC_A
    logic [31:0] macc;
    logic mtick;
    logic mon_on = 1'b0;
    always @(posedge clk) begin
        if (rst_a) begin
            macc  <= '0;
            mtick <= 1'b0;
        end else if (en_a) {mtick, macc} <= {1'b0, macc} + {1'b0, INC_A};
        else mtick <= 1'b0;
    end
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            chk("a_tick_vs_model", tick_a, mtick);
            if (ss_a) chk("a_sck_idle", sck_a, 1);
        end
    end

    typedef struct packed {
        logic rst, en, clr;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[24];

    function automatic logic [12:0] mk(input logic t, s, c, l, r, d, b, o, input logic [4:0] bi);
        return {t, s, c, l, r, d, b, o, bi};
    endfunction

    task automatic wait_tick(input string name, output int t);
        bit found = 1'b0;
        t = -1;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(posedge clk); #1;
            if (tick_a) begin
                found = 1'b1;
                t = cyc;
            end
        end
        chk({name, "_seen"}, found, 1);
    endtask

    task automatic check_frame(input string nm);
        int k = 0, leads = 0, trails = 0, first_lead = -1, first_sck = -1;
        int last_edge = -1, gap_bad = 0, bit_bad = 0, done_early = 0;
        @(posedge clk); #1;
        chk({nm, "_ss_fall"}, ss_a, 0);
        while (!ss_a && k < 2000) begin
            if (lead_a) begin
                if (first_lead < 0) begin
                    first_lead = k;
                    first_sck = int'(sck_a);
                end
                leads++;
            end
            if (trail_a) begin
                if (bit_a != 5'(15 - trails)) bit_bad++;
                trails++;
            end
            if (lead_a || trail_a) begin
                if (last_edge >= 0 && k - last_edge != 20) gap_bad++;
                last_edge = k;
            end
            if (done_a) done_early++;
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_ss_low_len"}, k, 680);
        chk({nm, "_leads"}, leads, 16);
        chk({nm, "_trails"}, trails, 16);
        chk({nm, "_first_lead_ofs"}, first_lead, 40);
        chk({nm, "_first_edge_sck"}, first_sck, 0);
        chk({nm, "_edge_gap_errs"}, gap_bad, 0);
        chk({nm, "_bit_idx_errs"}, bit_bad, 0);
        chk({nm, "_done_while_low"}, done_early, 0);
        chk({nm, "_done_at_rise"}, done_a, 1);
        chk({nm, "_busy_at_rise"}, busy_a, 0);
        chk({nm, "_bit_idx_reload"}, bit_a, 15);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t[11];
        int cnt;
        bit found;
        //                 rst   en    clr       tick ss sck ld tr dn bz ov bit
        tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd1)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd1)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 5'd1)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0, 5'd1)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 1, 0, 5'd1)};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 1, 1, 5'd1)};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1, 0, 1, 1, 5'd1)};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 1, 1, 5'd0)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1, 0, 1, 1, 5'd0)};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1, 0, 1, 5'd1)};
        tbl[10] = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 5'd1)};
        tbl[11] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0, 5'd1)};
        tbl[12] = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 1, 0, 5'd1)};
        tbl[13] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 1, 1, 0, 0, 1, 1, 5'd1)};
        tbl[14] = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1, 0, 1, 1, 5'd1)};
        tbl[15] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 1, 1, 0, 0, 1, 1, 5'd0)};
        tbl[16] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 0, 1, 0, 5'd0)};
        tbl[17] = '{1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 1, 0, 0, 5'd1)};
        tbl[18] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 1, 5'd1)};
        tbl[19] = '{1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 1, 5'd1)};
        tbl[20] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 1, 5'd1)};
        tbl[21] = '{1'b1, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd1)};
        tbl[22] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 5'd1)};
        tbl[23] = '{1'b0, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 5'd1)};

        for (int i = 0; i < 24; i++) begin
            rst_c = tbl[i].rst;
            en_c  = tbl[i].en;
            clr_c = tbl[i].clr;
            @(posedge clk); #1;
            chk($sformatf("c_vec%0d", i),
                {tick_c, ss_c, sck_c, lead_c, trail_c, done_c, busy_c, ov_c, bit_c}, tbl[i].exp);
        end

        chk("a_reset_state", {tick_a, ss_a, sck_a, lead_a, trail_a, done_a, busy_a, ov_a, bit_a},
            mk(0, 1, 1, 0, 0, 0, 0, 0, 5'd15));
        rst_a  = 1'b0;
        en_a   = 1'b1;
        mon_on = 1'b1;

        wait_tick("a_tick0", t[0]);
        check_frame("a_frame1");
        for (int i = 1; i <= 10; i++) begin
            wait_tick($sformatf("a_tick%0d", i), t[i]);
            chk_in($sformatf("a_interval%0d", i), t[i] - t[i-1], 2267, 2268);
        end
        chk_in("a_interval_sum", t[10] - t[0], 22675, 22676);

        wait_tick("a_tick_before_disable", t[0]);
        repeat (100) @(posedge clk);
        #1;
        en_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(posedge clk); #1;
            if (done_a) found = 1'b1;
        end
        chk("a_frame_done_while_disabled", found, 1);
        cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (tick_a) cnt++;
        end
        chk("a_ticks_while_disabled", cnt, 0);
        en_a = 1'b1;
        wait_tick("a_tick_reenable", t[0]);

        repeat (200) @(posedge clk);
        #1;
        chk("a_mid_shift", {ss_a, busy_a}, 2'b01);
        rst_a = 1'b1;
        @(posedge clk); #1;
        chk("a_rst_mid_frame", {ss_a, sck_a, busy_a, done_a, tick_a, ov_a, bit_a},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15});
        rst_a = 1'b0;
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (done_a) cnt++;
        end
        chk("a_no_done_after_rst", cnt, 0);
        wait_tick("a_tick_after_rst", t[0]);
        check_frame("a_frame2");
        chk("a_no_overrun", ov_a, 0);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
